// File: rtl/cpu_types_pkg.sv
// Shared types for the CPU pipeline: word type, fetch FSM states and the
// sequential PC increment used by the instruction-fetch stage.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PEND   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam word_t PC_STEP = 32'd4;

  // Instruction addresses are word aligned; drop the two byte-offset bits.
  function automatic word_t word_align(input word_t addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/fetch_perf_counters.sv
// Fetch-stage performance counters: instructions delivered to IF/ID and
// cycles spent requesting without delivering. Only instantiated when
// FETCH_PERF_EN is defined.
module fetch_perf_counters
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  fetch_inc,
  input  logic  stall_inc,
  output word_t fetch_count,
  output word_t fetch_stall_count
);

  word_t fetch_count_q, fetch_count_d;
  word_t stall_count_q, stall_count_d;

  // Next counter values; both wrap silently at 2^32.
  always_comb begin
    fetch_count_d = fetch_count_q;
    stall_count_d = stall_count_q;
    if (fetch_inc) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end else begin
      fetch_count_d = fetch_count_q;
    end
    if (stall_inc) begin
      stall_count_d = stall_count_q + 32'd1;
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // Counter registers with asynchronous clear.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fetch_count_q <= 32'd0;
      stall_count_q <= 32'd0;
    end else begin
      fetch_count_q <= fetch_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign fetch_count       = fetch_count_q;
  assign fetch_stall_count = stall_count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the imem request/ihit
// handshake, absorbs branch/jump redirects (including those arriving while
// an access is still outstanding) and produces the IF/ID load/squash strobes.
// Optional feature macro: FETCH_PERF_EN adds fetch_count/fetch_stall_count.
module fetch_stage
  import cpu_types_pkg::word_t;
  import cpu_types_pkg::fetch_state_t;
  import cpu_types_pkg::RUN;
  import cpu_types_pkg::PEND;
  import cpu_types_pkg::HALTED;
  import cpu_types_pkg::word_align;
#(
  parameter word_t PC0     = 32'h0000_0000,
  parameter word_t PC_STEP = 32'd4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] iload,
  output logic [31:0] npc_in,
  output logic        ifid_enable,
  output logic        ifid_flush
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] fetch_stall_count
`endif
);

  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        tgt_q, tgt_d;
  word_t        redirect_aligned;

  assign redirect_aligned = word_align(redirect_pc);

  // Next-state, PC/target update and IF/ID strobes. Priority each cycle is
  // halt > redirect > stall > sequential. While an access is outstanding the
  // address must not move, so a redirect without ihit parks its target.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    tgt_d       = tgt_q;
    ifid_enable = 1'b0;
    ifid_flush  = 1'b0;
    case (state_q)
      RUN: begin
        if (halt) begin
          ifid_flush = 1'b1;
          state_d    = HALTED;
        end else if (redirect_valid) begin
          ifid_flush = 1'b1;
          if (ihit) begin
            pc_d = redirect_aligned;
          end else begin
            tgt_d   = redirect_aligned;
            state_d = PEND;
          end
        end else if (ihit && !stall) begin
          ifid_enable = 1'b1;
          pc_d        = pc_q + PC_STEP;
        end else begin
          pc_d = pc_q;
        end
      end
      PEND: begin
        // The word returned for the stale address is never loaded.
        if (halt) begin
          ifid_flush = 1'b1;
          state_d    = HALTED;
        end else if (redirect_valid) begin
          ifid_flush = 1'b1;
          if (ihit) begin
            pc_d    = redirect_aligned;
            state_d = RUN;
          end else begin
            tgt_d = redirect_aligned;
          end
        end else if (ihit) begin
          pc_d    = tgt_q;
          state_d = RUN;
        end else begin
          pc_d = pc_q;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = RUN;
        pc_d    = PC0;
        tgt_d   = 32'd0;
      end
    endcase
  end

  // State, PC and parked-target registers; reset abandons any access.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      pc_q    <= PC0;
      tgt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
    end
  end

  assign imemREN  = (state_q != HALTED);
  assign imemaddr = pc_q;
  assign iload    = imemload;
  assign npc_in   = pc_q + PC_STEP;

`ifdef FETCH_PERF_EN
  fetch_perf_counters u_perf (
    .CLK               (CLK),
    .nRST              (nRST),
    .fetch_inc         (ifid_enable),
    .stall_inc         (imemREN && !ifid_enable),
    .fetch_count       (fetch_count),
    .fetch_stall_count (fetch_stall_count)
  );
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table covering the
// documented scenarios, hand-written reset sequences, and random stimulus
// checked against a behavioural model of the fetch rules.
module tb_fetch_stage;

  logic        CLK;
  logic        nRST;
  logic        ihit;
  logic [31:0] imemload;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [31:0] iload;
  logic [31:0] npc_in;
  logic        ifid_enable;
  logic        ifid_flush;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] fetch_stall_count;
`endif

  fetch_stage dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .ihit           (ihit),
    .imemload       (imemload),
    .imemREN        (imemREN),
    .imemaddr       (imemaddr),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .iload          (iload),
    .npc_in         (npc_in),
    .ifid_enable    (ifid_enable),
    .ifid_flush     (ifid_flush)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count       (fetch_count),
    .fetch_stall_count (fetch_stall_count)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int checks = 0;
  int errors = 0;

  // Reference model: where fetching is, whether a redirect is parked.
  logic [31:0] m_pc, m_tgt;
  bit          m_pend, m_halted;
  logic [31:0] m_fc, m_sc;

  // Outputs sampled mid-cycle by step().
  logic [31:0] s_addr;
  logic        s_ren, s_en, s_flush;

  typedef struct {
    logic        ihit;
    logic        stall;
    logic        rv;
    logic [31:0] rpc;
    logic        halt;
    logic [31:0] addr;
    logic        ren;
    logic        en;
    logic        flush;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_tgt = 32'h0; m_pend = 0; m_halted = 0; m_fc = 32'h0; m_sc = 32'h0;
  endtask

  // One cycle: drive at posedge+1, sample/compare at posedge+5, advance.
  task automatic step(input logic i_hit, input logic i_stall, input logic i_rv,
                      input logic [31:0] i_rpc, input logic i_halt);
    logic        e_ren, e_en, e_flush;
    logic [31:0] word, al;
    word = $urandom;
    ihit = i_hit; stall = i_stall; redirect_valid = i_rv; redirect_pc = i_rpc;
    halt = i_halt; imemload = word;
    #4;
    e_ren   = !m_halted;
    e_en    = !m_halted && !m_pend && !i_halt && !i_rv && i_hit && !i_stall;
    e_flush = !m_halted && (i_halt || i_rv);
    s_addr = imemaddr; s_ren = imemREN; s_en = ifid_enable; s_flush = ifid_flush;
    chk("model_imemREN", {31'd0, imemREN}, {31'd0, e_ren});
    chk("model_imemaddr", imemaddr, m_pc);
    chk("model_npc_in", npc_in, m_pc + 32'd4);
    chk("model_ifid_enable", {31'd0, ifid_enable}, {31'd0, e_en});
    chk("model_ifid_flush", {31'd0, ifid_flush}, {31'd0, e_flush});
    chk("model_iload", iload, word);
`ifdef FETCH_PERF_EN
    chk("model_fetch_count", fetch_count, m_fc);
    chk("model_fetch_stall_count", fetch_stall_count, m_sc);
`endif
    if (e_en) m_fc = m_fc + 32'd1;
    if (e_ren && !e_en) m_sc = m_sc + 32'd1;
    al = {i_rpc[31:2], 2'b00};
    if (!m_halted) begin
      if (i_halt) m_halted = 1;
      else if (i_rv) begin
        if (i_hit) begin m_pc = al; m_pend = 0; end
        else begin m_tgt = al; m_pend = 1; end
      end else if (m_pend) begin
        if (i_hit) begin m_pc = m_tgt; m_pend = 0; end
      end else if (i_hit && !i_stall) m_pc = m_pc + 32'd4;
    end
    @(posedge CLK); #1;
  endtask

  // Asynchronous reset dropped mid-cycle, with an immediate address check.
  task automatic mid_reset();
    ihit = 1'b0; stall = 1'b0; redirect_valid = 1'b0; halt = 1'b0;
    #2 nRST = 1'b0;
    #1;
    chk("reset_async_imemaddr", imemaddr, 32'h0);
    chk("reset_async_imemREN", {31'd0, imemREN}, 32'd1);
    chk("reset_async_flush", {31'd0, ifid_flush}, 32'd0);
    #1 nRST = 1'b1;
    model_reset();
    @(posedge CLK); #1;
  endtask

  task automatic addv(input logic h, input logic s, input logic rv, input logic [31:0] rpc,
                      input logic hl, input logic [31:0] a, input logic r, input logic e,
                      input logic f);
    vec_t v;
    v.ihit = h; v.stall = s; v.rv = rv; v.rpc = rpc; v.halt = hl;
    v.addr = a; v.ren = r; v.en = e; v.flush = f;
    vecs.push_back(v);
  endtask

  initial begin
    nRST = 1'b0; ihit = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'h0; halt = 1'b0; imemload = 32'h0;
    model_reset();

    // Sequential fetch, stall hold, redirect with/without ihit, newest
    // target wins, PC wrap, halt with concurrent redirect.
    addv(1,0,0,32'h0,0, 32'h0,1,1,0);
    addv(1,0,0,32'h0,0, 32'h4,1,1,0);
    addv(1,0,0,32'h0,0, 32'h8,1,1,0);
    addv(1,0,0,32'h0,0, 32'hC,1,1,0);
    for (int i = 0; i < 3; i++) addv(1,1,0,32'h0,0, 32'h10,1,0,0);
    addv(1,0,0,32'h0,0, 32'h10,1,1,0);
    addv(1,0,0,32'h0,0, 32'h14,1,1,0);
    addv(1,0,1,32'h9,0, 32'h18,1,0,1);
    addv(1,0,1,32'h203,0, 32'h8,1,0,1);
    addv(0,0,0,32'h0,0, 32'h200,1,0,0);
    addv(0,0,1,32'h100,0, 32'h200,1,0,1);
    addv(0,0,0,32'h0,0, 32'h200,1,0,0);
    addv(0,0,0,32'h0,0, 32'h200,1,0,0);
    addv(1,0,0,32'h0,0, 32'h200,1,0,0);
    addv(1,0,0,32'h0,0, 32'h100,1,1,0);
    addv(0,0,1,32'h150,0, 32'h104,1,0,1);
    addv(0,0,1,32'h300,0, 32'h104,1,0,1);
    addv(1,0,0,32'h0,0, 32'h104,1,0,0);
    addv(0,0,0,32'h0,0, 32'h300,1,0,0);
    addv(1,0,1,32'hFFFF_FFFF,0, 32'h300,1,0,1);
    addv(1,0,0,32'h0,0, 32'hFFFF_FFFC,1,1,0);
    addv(0,0,0,32'h0,0, 32'h0,1,0,0);
    addv(1,0,1,32'h40,1, 32'h0,1,0,1);
    addv(1,0,1,32'h80,0, 32'h0,0,0,0);
    addv(1,0,0,32'h0,0, 32'h0,0,0,0);

    // Reset state.
    #12;
    chk("reset_imemREN", {31'd0, imemREN}, 32'd1);
    chk("reset_imemaddr", imemaddr, 32'h0);
    chk("reset_npc_in", npc_in, 32'h4);
    chk("reset_ifid_enable", {31'd0, ifid_enable}, 32'd0);
    chk("reset_ifid_flush", {31'd0, ifid_flush}, 32'd0);
    chk("reset_iload", iload, 32'h0);
    nRST = 1'b1;
    @(posedge CLK); #1;

    foreach (vecs[i]) begin
      step(vecs[i].ihit, vecs[i].stall, vecs[i].rv, vecs[i].rpc, vecs[i].halt);
      chk($sformatf("vec%0d_imemaddr", i), s_addr, vecs[i].addr);
      chk($sformatf("vec%0d_imemREN", i), {31'd0, s_ren}, {31'd0, vecs[i].ren});
      chk($sformatf("vec%0d_ifid_enable", i), {31'd0, s_en}, {31'd0, vecs[i].en});
      chk($sformatf("vec%0d_ifid_flush", i), {31'd0, s_flush}, {31'd0, vecs[i].flush});
    end

    // Reset out of HALTED, then reset with an access in flight at pc=8.
    mid_reset();
    step(1,0,0,32'h0,0);
    step(1,0,0,32'h0,0);
    chk("seq_pc_before_reset", imemaddr, 32'h8);
    mid_reset();
    step(1,0,0,32'h0,0);

    // Randomised traffic with occasional asynchronous resets.
    for (int c = 0; c < 1500; c++) begin
      if ((c % 97) == 96) mid_reset();
      step(($urandom % 4) != 0, ($urandom % 4) == 0, ($urandom % 8) == 0,
           $urandom, ($urandom % 150) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
